jam_cost_server: RTL and testbench
==================================

Name: jam_cost_server

Overview:
Responder side of the JAM cost-lookup interface. It loads an 8x8 table of 7-bit costs (worker x job) over a valid/ready stream, holds the JAM core in reset until loading completes, and then answers JAM's W/J lookups with a same-cycle Cost. It also times the run, captures MinCost/MatchCount on Valid, and compares them against golden values. It sits beside JAM in the prototype/self-check wrapper and replaces the bench-side cost ROM.

Parameters:
HOLD_CYC, 2, number of cycles JAM_RST stays high after the table is loaded (1..15)
TIMEOUT_CYC, 10000000, maximum number of RUN cycles to wait for Valid
CNT_W, 24, width of the run-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-low
LD_VALID  in  1  load word valid
LD_READY  out  1  load word accepted when LD_VALID && LD_READY
LD_DATA  in  7  cost word; row-major order, index = 8*worker + job
JAM_RST  out  1  active-high reset driven to JAM core
W  in  3  worker index from JAM
J  in  3  job index from JAM
Cost  out  7  table[8*W+J], combinational
Valid  in  1  JAM result valid
MinCost  in  9  JAM result
MatchCount  in  4  JAM result
GOLD_MIN  in  9  expected MinCost, static during run
GOLD_MATCH  in  4  expected MatchCount, static during run
DONE  out  1  run finished (result or timeout), sticky
PASS  out  1  result matched golden; meaningful only when DONE=1
TIMEOUT  out  1  run ended without Valid, sticky
CYCLES  out  CNT_W  RUN cycles up to and including the Valid cycle
RES_MIN  out  9  captured MinCost
RES_MATCH  out  4  captured MatchCount

Behaviour:
- States: LOAD, RELEASE, RUN, FIN, TOUT.
- RST=0 sampled: state=LOAD, load index=0, JAM_RST=1, DONE=0, PASS=0, TIMEOUT=0, CYCLES=0, RES_MIN=0, RES_MATCH=0, hold/run counters=0. Table storage is not reset and keeps its old contents; a full reload is still required. Reset applied mid-operation behaves the same way.
- LOAD: LD_READY=1. Each accepted word writes table[index], then index++. The accept of index 63 moves to RELEASE. LD_VALID=0 stalls with no state change. Outside LOAD, LD_READY=0 and LD_VALID is ignored.
- RELEASE: JAM_RST=1 for exactly HOLD_CYC cycles, then RUN. Valid is ignored.
- JAM_RST=1 in LOAD, RELEASE, FIN and TOUT; JAM_RST=0 only in RUN.
- RUN: the run counter is cleared on entry and counts RUN cycles (k=1 for the first RUN cycle).
  - Valid=1 in cycle k: go to FIN. Register CYCLES=k, RES_MIN=MinCost, RES_MATCH=MatchCount, PASS=(MinCost==GOLD_MIN && MatchCount==GOLD_MATCH), DONE=1.
  - No Valid by cycle k=TIMEOUT_CYC: go to TOUT with TIMEOUT=1, DONE=1, PASS=0, CYCLES=TIMEOUT_CYC.
  - Valid in cycle k=TIMEOUT_CYC: FIN wins.
- FIN/TOUT: terminal until reset. Outputs hold and later Valid pulses are ignored.
- Cost = table[{W,J}], a pure combinational read valid in every state, with zero-cycle latency (JAM samples it in the same cycle). W/J values are unchecked and always in range (3 bits each).
- All outputs except Cost are registered.

Test Plan:
- Load a table with cost(w,j)=8*w+j (mod 128), including a 5-cycle LD_VALID gap at index 20. Then: LD_READY drops after the 64th accept; JAM_RST falls exactly HOLD_CYC=2 cycles later; W=5,J=3 gives Cost=43; the index-20 entry holds its value.
- JAM model with GOLD_MIN=9'd285, GOLD_MATCH=4'd1; Valid pulses in RUN cycle 1234 with MinCost=285, MatchCount=1 -> DONE=1, PASS=1, CYCLES=1234, RES_MIN=285, RES_MATCH=1, JAM_RST=1 next cycle.
- Same run with MinCost=286 -> DONE=1, PASS=0, RES_MIN=286, TIMEOUT=0.
- TIMEOUT_CYC=100, Valid never asserted -> TIMEOUT=1, DONE=1, PASS=0, CYCLES=100. A Valid pulse afterwards changes nothing.
- Valid exactly at cycle 100 with TIMEOUT_CYC=100 -> FIN, TIMEOUT=0, CYCLES=100.
- RST=0 for one cycle at load index 30 and again mid-RUN -> both return to LOAD with index 0 and all outputs at reset values; Valid during RELEASE is ignored.

Source files
------------

// File: rtl/jam_cost_server.sv
// jam_cost_server
// Responder side of the JAM cost-lookup interface. Loads an 8x8 table of
// 7-bit costs over a valid/ready stream, holds the JAM core in reset until the
// table is complete, answers W/J lookups combinationally, times the run and
// compares the captured result against golden values.
//
// Ports:
//   CLK, RST            clock, synchronous active-low reset
//   LD_VALID/LD_READY   load handshake, LD_DATA = cost word (row-major 8*w+j)
//   JAM_RST             active-high reset to the JAM core (low only in RUN)
//   W, J, Cost          same-cycle table lookup
//   Valid, MinCost,
//   MatchCount          JAM result
//   GOLD_MIN/GOLD_MATCH golden result, static during the run
//   DONE, PASS, TIMEOUT sticky run status
//   CYCLES              RUN cycles up to and including the Valid cycle
//   RES_MIN, RES_MATCH  captured result
module jam_cost_server #(
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int CNT_W       = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_VALID,
  output logic             LD_READY,
  input  logic [6:0]       LD_DATA,
  output logic             JAM_RST,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output logic [6:0]       Cost,
  input  logic             Valid,
  input  logic [8:0]       MinCost,
  input  logic [3:0]       MatchCount,
  input  logic [8:0]       GOLD_MIN,
  input  logic [3:0]       GOLD_MATCH,
  output logic             DONE,
  output logic             PASS,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] CYCLES,
  output logic [8:0]       RES_MIN,
  output logic [3:0]       RES_MATCH
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_FIN     = 3'd3,
    S_TOUT    = 3'd4
  } state_t;

  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TOUT_K    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_idx;
  logic [3:0]       r_hold;
  logic [CNT_W-1:0] r_run;
  logic [6:0]       r_tab [0:63];

  logic             r_ld_ready;
  logic             r_jam_rst;
  logic             r_done;
  logic             r_pass;
  logic             r_tout;
  logic [CNT_W-1:0] r_cycles;
  logic [8:0]       r_res_min;
  logic [3:0]       r_res_match;

  logic             w_accept;
  logic [CNT_W-1:0] w_k;
  logic             w_fin;
  logic             w_tmo;
  logic             w_ld_ready_nx;
  logic             w_jam_rst_nx;
  logic             w_pass_nx;

  // Handshake and run-cycle number of the current RUN cycle (k starts at 1).
  assign w_accept = (r_state == S_LOAD) && LD_VALID && RST;
  assign w_k      = r_run + CNT_ONE;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (LD_VALID && (r_idx == 6'd63)) begin
          w_next = S_RELEASE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_RELEASE: begin
        if (r_hold == HOLD_LAST) begin
          w_next = S_RUN;
        end else begin
          w_next = S_RELEASE;
        end
      end
      S_RUN: begin
        // Valid in the final allowed cycle still counts as a result.
        if (Valid) begin
          w_next = S_FIN;
        end else if (w_k == TOUT_K) begin
          w_next = S_TOUT;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FIN:   w_next = S_FIN;
      S_TOUT:  w_next = S_TOUT;
      default: w_next = S_LOAD;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    w_ld_ready_nx = (w_next == S_LOAD);
    w_jam_rst_nx  = (w_next != S_RUN);
    w_fin         = (r_state == S_RUN) && Valid;
    w_tmo         = (r_state == S_RUN) && !Valid && (w_k == TOUT_K);
    w_pass_nx     = (MinCost == GOLD_MIN) && (MatchCount == GOLD_MATCH);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_LOAD;
      r_idx       <= 6'd0;
      r_hold      <= 4'd0;
      r_run       <= '0;
      r_ld_ready  <= 1'b1;
      r_jam_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_tout      <= 1'b0;
      r_cycles    <= '0;
      r_res_min   <= 9'd0;
      r_res_match <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_ld_ready <= w_ld_ready_nx;
      r_jam_rst  <= w_jam_rst_nx;
      if (w_accept) begin
        r_idx <= r_idx + 6'd1;
      end
      // Both counters sit at zero outside their state, so entry starts clean.
      if (r_state == S_RELEASE) begin
        r_hold <= r_hold + 4'd1;
      end else begin
        r_hold <= 4'd0;
      end
      if (r_state == S_RUN) begin
        r_run <= w_k;
      end else begin
        r_run <= '0;
      end
      if (w_fin) begin
        r_done      <= 1'b1;
        r_pass      <= w_pass_nx;
        r_cycles    <= w_k;
        r_res_min   <= MinCost;
        r_res_match <= MatchCount;
      end else if (w_tmo) begin
        r_done   <= 1'b1;
        r_tout   <= 1'b1;
        r_pass   <= 1'b0;
        r_cycles <= TOUT_K;
      end
    end
  end

  // Cost table storage; deliberately not reset, a reload always follows reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_tab[r_idx] <= LD_DATA;
    end
  end

  assign Cost      = r_tab[{W, J}];
  assign LD_READY  = r_ld_ready;
  assign JAM_RST   = r_jam_rst;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign TIMEOUT   = r_tout;
  assign CYCLES    = r_cycles;
  assign RES_MIN   = r_res_min;
  assign RES_MATCH = r_res_match;

endmodule

// File: tb/tb_jam_cost_server.sv
// Testbench for jam_cost_server. Two instances share all inputs: dut_a uses the
// default timeout, dut_b uses TIMEOUT_CYC=100. Run results are checked through
// per-instance scoreboard queues popped by a monitor on each DONE rise.
module tb_jam_cost_server;

  logic        CLK;
  logic        RST;
  logic        LD_VALID;
  logic [6:0]  LD_DATA;
  logic [2:0]  W;
  logic [2:0]  J;
  logic        Valid;
  logic [8:0]  MinCost;
  logic [3:0]  MatchCount;
  logic [8:0]  GOLD_MIN;
  logic [3:0]  GOLD_MATCH;

  logic        LD_READY_a, JAM_RST_a, DONE_a, PASS_a, TIMEOUT_a;
  logic [6:0]  Cost_a;
  logic [23:0] CYCLES_a;
  logic [8:0]  RES_MIN_a;
  logic [3:0]  RES_MATCH_a;
  logic        LD_READY_b, JAM_RST_b, DONE_b, PASS_b, TIMEOUT_b;
  logic [6:0]  Cost_b;
  logic [23:0] CYCLES_b;
  logic [8:0]  RES_MIN_b;
  logic [3:0]  RES_MATCH_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic        tout;
    logic [23:0] cyc;
    logic [8:0]  mn;
    logic [3:0]  mt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  jam_cost_server #(.HOLD_CYC(2), .TIMEOUT_CYC(10000000), .CNT_W(24)) dut_a (
    .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_READY(LD_READY_a),
    .LD_DATA(LD_DATA), .JAM_RST(JAM_RST_a), .W(W), .J(J), .Cost(Cost_a),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
    .GOLD_MIN(GOLD_MIN), .GOLD_MATCH(GOLD_MATCH), .DONE(DONE_a),
    .PASS(PASS_a), .TIMEOUT(TIMEOUT_a), .CYCLES(CYCLES_a),
    .RES_MIN(RES_MIN_a), .RES_MATCH(RES_MATCH_a)
  );

  jam_cost_server #(.HOLD_CYC(2), .TIMEOUT_CYC(100), .CNT_W(24)) dut_b (
    .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_READY(LD_READY_b),
    .LD_DATA(LD_DATA), .JAM_RST(JAM_RST_b), .W(W), .J(J), .Cost(Cost_b),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
    .GOLD_MIN(GOLD_MIN), .GOLD_MATCH(GOLD_MATCH), .DONE(DONE_b),
    .PASS(PASS_b), .TIMEOUT(TIMEOUT_b), .CYCLES(CYCLES_b),
    .RES_MIN(RES_MIN_b), .RES_MATCH(RES_MATCH_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input exp_t e, input logic pass, input logic tout,
                        input logic jr, input logic [23:0] cyc, input logic [8:0] mn,
                        input logic [3:0] mt);
    chk({tag, "_pass"}, pass, e.pass);
    chk({tag, "_timeout"}, tout, e.tout);
    chk({tag, "_cycles"}, cyc, e.cyc);
    chk({tag, "_res_min"}, mn, e.mn);
    chk({tag, "_res_match"}, mt, e.mt);
    chk({tag, "_jam_rst_after_done"}, jr, 1'b1);
  endtask

  // Monitor: every DONE rise must match the oldest expected result.
  initial begin
    logic prev_a;
    logic prev_b;
    exp_t e;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge CLK);
      if (DONE_a === 1'b1 && !prev_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_done", DONE_a, 1'b0);
        end else begin
          e = q_a.pop_front();
          sb_cmp("a", e, PASS_a, TIMEOUT_a, JAM_RST_a, CYCLES_a, RES_MIN_a, RES_MATCH_a);
        end
      end
      if (DONE_b === 1'b1 && !prev_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_done", DONE_b, 1'b0);
        end else begin
          e = q_b.pop_front();
          sb_cmp("b", e, PASS_b, TIMEOUT_b, JAM_RST_b, CYCLES_b, RES_MIN_b, RES_MATCH_b);
        end
      end
      prev_a = (DONE_a === 1'b1);
      prev_b = (DONE_b === 1'b1);
    end
  end

  task automatic push_exp(input logic [1:0] which, input logic pass, input logic tout,
                          input logic [23:0] cyc, input logic [8:0] mn, input logic [3:0] mt);
    exp_t e;
    e.pass = pass; e.tout = tout; e.cyc = cyc; e.mn = mn; e.mt = mt;
    if (which[0]) q_a.push_back(e);
    if (which[1]) q_b.push_back(e);
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_ld_ready"}, LD_READY_a, 1'b1);
    chk({tag, "_a_jam_rst"}, JAM_RST_a, 1'b1);
    chk({tag, "_a_done"}, DONE_a, 1'b0);
    chk({tag, "_a_pass"}, PASS_a, 1'b0);
    chk({tag, "_a_timeout"}, TIMEOUT_a, 1'b0);
    chk({tag, "_a_cycles"}, CYCLES_a, 24'd0);
    chk({tag, "_a_res_min"}, RES_MIN_a, 9'd0);
    chk({tag, "_a_res_match"}, RES_MATCH_a, 4'd0);
    chk({tag, "_b_done"}, DONE_b, 1'b0);
    chk({tag, "_b_timeout"}, TIMEOUT_b, 1'b0);
    chk({tag, "_b_cycles"}, CYCLES_b, 24'd0);
  endtask

  // Streams words 0..n-1 (value = index); a 5-cycle invalid gap before gap_at.
  task automatic load_words(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        LD_VALID = 1'b0;
        LD_DATA  = 7'h7F;
        repeat (5) begin @(posedge CLK); #1; end
      end
      LD_VALID = 1'b1;
      LD_DATA  = 7'(i);
      chk("ld_ready_during_load", LD_READY_a, 1'b1);
      @(posedge CLK); #1;
    end
    LD_VALID = 1'b0;
    LD_DATA  = 7'h7F;
  endtask

  // JAM model: waits for release, raises Valid in RUN cycle k_valid.
  task automatic run_jam(input int k_valid, input logic [8:0] mn, input logic [3:0] mt);
    int n;
    n = 0;
    while (JAM_RST_a !== 1'b0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("jam_rst_released", JAM_RST_a, 1'b0);
    for (int k = 1; k < k_valid; k++) begin
      @(posedge CLK); #1;
    end
    Valid = 1'b1; MinCost = mn; MatchCount = mt;
    @(posedge CLK); #1;
    Valid = 1'b0; MinCost = 9'd0; MatchCount = 4'd0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; LD_VALID = 1'b0; LD_DATA = 7'd0; W = 3'd0; J = 3'd0;
    Valid = 1'b0; MinCost = 9'd0; MatchCount = 4'd0;
    GOLD_MIN = 9'd285; GOLD_MATCH = 4'd1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    chk_reset("rst0");

    // Reset partway through loading, then a full reload with a gap at 20.
    load_words(30, -1);
    pulse_reset();
    chk_reset("rst_load30");
    load_words(64, 20);
    chk("ld_ready_after_64", LD_READY_a, 1'b0);
    chk("jam_rst_release1", JAM_RST_a, 1'b1);
    @(posedge CLK); #1;
    chk("jam_rst_release2", JAM_RST_a, 1'b1);
    @(posedge CLK); #1;
    chk("jam_rst_run", JAM_RST_a, 1'b0);
    chk("b_jam_rst_run", JAM_RST_b, 1'b0);

    // Matching result at cycle 1234; dut_b times out at 100 first.
    push_exp(2'b01, 1'b1, 1'b0, 24'd1234, 9'd285, 4'd1);
    push_exp(2'b10, 1'b0, 1'b1, 24'd100, 9'd0, 4'd0);
    run_jam(1234, 9'd285, 4'd1);
    @(negedge CLK);
    chk("b_tout_hold_timeout", TIMEOUT_b, 1'b1);
    chk("b_tout_hold_done", DONE_b, 1'b1);
    chk("b_tout_hold_pass", PASS_b, 1'b0);
    chk("b_tout_hold_cycles", CYCLES_b, 24'd100);
    chk("b_tout_hold_res_min", RES_MIN_b, 9'd0);

    // A later Valid in FIN is ignored.
    Valid = 1'b1; MinCost = 9'd7; MatchCount = 4'd3;
    @(posedge CLK); #1;
    Valid = 1'b0;
    @(posedge CLK); #1;
    chk("a_fin_hold_cycles", CYCLES_a, 24'd1234);
    chk("a_fin_hold_res_min", RES_MIN_a, 9'd285);
    chk("a_fin_hold_pass", PASS_a, 1'b1);

    // Table contents after the gapped load.
    W = 3'd5; J = 3'd3; #1;
    chk("cost_w5_j3", Cost_a, 7'd43);
    W = 3'd2; J = 3'd4; #1;
    chk("cost_idx20", Cost_a, 7'd20);
    chk("b_cost_idx20", Cost_b, 7'd20);
    for (int i = 0; i < 64; i++) begin
      W = 3'(i / 8); J = 3'(i % 8); #1;
      chk("cost_table", Cost_a, 32'(i));
    end

    // Mismatching result exactly at cycle 100; Valid in RELEASE ignored.
    pulse_reset();
    chk_reset("rst_after_fin");
    load_words(64, -1);
    Valid = 1'b1; MinCost = 9'd1; MatchCount = 4'd1;
    @(posedge CLK); #1;
    Valid = 1'b0;
    push_exp(2'b11, 1'b0, 1'b0, 24'd100, 9'd286, 4'd1);
    run_jam(100, 9'd286, 4'd1);
    @(negedge CLK);
    chk("b_fin_wins_timeout", TIMEOUT_b, 1'b0);

    // Reset in the middle of RUN, then a short clean run.
    pulse_reset();
    load_words(64, -1);
    repeat (52) begin @(posedge CLK); #1; end
    chk("midrun_jam_rst", JAM_RST_a, 1'b0);
    pulse_reset();
    chk_reset("rst_midrun");
    load_words(64, -1);
    push_exp(2'b11, 1'b1, 1'b0, 24'd5, 9'd285, 4'd1);
    run_jam(5, 9'd285, 4'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
